// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler owning HI/LO for the five-stage pipeline
//
// Sequences multi-cycle mult/multu/div/divu issued from E, applies mthi/mtlo,
// and raises the D-stage stall for HI/LO users while an operation is in flight.
// The result is computed at issue and held in pending registers until the
// busy count expires, so HI/LO change only at commit.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, clears all state
//   IntReq     flush of the E-stage instruction this cycle
//   E_MDop_i   E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   E_A_i      rs operand
//   E_B_i      rt operand
//   D_MDuse_i  D-stage instruction touches the mult/div unit
//   E_busy_o   operation in flight
//   D_stall_o  stall for the D stage (combinational)
//   HI_o/LO_o  architectural HI/LO
//   done_o     one-cycle pulse in the cycle after HI/LO commit

module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IntReq,
    input  logic [3:0]  E_MDop_i,
    input  logic [31:0] E_A_i,
    input  logic [31:0] E_B_i,
    input  logic        D_MDuse_i,
    output logic        E_busy_o,
    output logic        D_stall_o,
    output logic [31:0] HI_o,
    output logic [31:0] LO_o,
    output logic        done_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic        state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_sup;

    logic        start;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_den;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign start     = (state == ST_IDLE) && !IntReq &&
                       (E_MDop_i >= OP_MULT) && (E_MDop_i <= OP_DIVU);
    assign is_div    = (E_MDop_i == OP_DIV) || (E_MDop_i == OP_DIVU);
    assign E_busy_o  = (state == ST_RUN);
    // Stall already in the start cycle so a dependent mfhi/mflo in D never
    // reads HI/LO before the new value commits.
    assign D_stall_o = D_MDuse_i && (start || E_busy_o);

    always_comb begin
        prod_s = $signed({{32{E_A_i[31]}}, E_A_i}) * $signed({{32{E_B_i[31]}}, E_B_i});
        prod_u = {32'd0, E_A_i} * {32'd0, E_B_i};
        // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to
        // 0x80000000 with remainder 0 instead of relying on simulator overflow.
        abs_a   = E_A_i[31] ? (32'd0 - E_A_i) : E_A_i;
        abs_b   = E_B_i[31] ? (32'd0 - E_B_i) : E_B_i;
        // A zero divisor never commits; the guard only keeps the divider defined.
        div_den = (abs_b == 32'd0) ? 32'd1 : abs_b;
        sq      = abs_a / div_den;
        sr      = abs_a % div_den;
        if (E_A_i[31] ^ E_B_i[31]) begin
            sq = 32'd0 - sq;
        end
        if (E_A_i[31]) begin
            sr = 32'd0 - sr;
        end
        uq = E_A_i / ((E_B_i == 32'd0) ? 32'd1 : E_B_i);
        ur = E_A_i % ((E_B_i == 32'd0) ? 32'd1 : E_B_i);

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (E_MDop_i)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = sr;            res_lo = sq;           end
            OP_DIVU:  begin res_hi = ur;            res_lo = uq;           end
            default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            pend_sup <= 1'b0;
            HI_o     <= 32'd0;
            LO_o     <= 32'd0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    pend_hi  <= res_hi;
                    pend_lo  <= res_lo;
                    pend_sup <= is_div && (E_B_i == 32'd0);
                    cnt      <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state    <= ST_RUN;
                end else if (!IntReq && (E_MDop_i == OP_MTHI)) begin
                    HI_o <= E_A_i;
                end else if (!IntReq && (E_MDop_i == OP_MTLO)) begin
                    LO_o <= E_A_i;
                end
            end else begin
                // Ops presented in E while running are ignored; the D stall
                // keeps them from arriving. IntReq cannot cancel a running op.
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (!pend_sup) begin
                        HI_o <= pend_hi;
                        LO_o <= pend_lo;
                    end
                    state  <= ST_IDLE;
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule
